fp_fp2int_seq: RTL and testbench

//  Converts an IEEE-754 binary16 value to an unsigned 16-bit integer, truncating toward zero.

---
 rtl/fp_fp2int_seq_pkg.sv | 28 ++
 rtl/fp_fp2int_seq_if.sv | 29 ++
 rtl/fp_fp16_classify.sv | 33 +++
 rtl/fp_fp2int_seq.sv | 123 ++++++++++++
 tb/tb_fp_fp2int_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_fp2int_seq_pkg.sv
// Shared FP16 field layout, constants and state/flag types for the
// binary16 to unsigned 16-bit integer converter.
package fp_fp2int_seq_pkg;

  localparam int FP16_W      = 16;
  localparam int EXP_W       = 5;
  localparam int MANT_W      = 10;
  localparam int INT_W       = 16;
  // Accumulator is Q16.10: 16 integer bits above the 10 mantissa bits.
  localparam int ACC_W       = INT_W + MANT_W;

  localparam logic [EXP_W-1:0] FP16_BIAS    = 5'd15;
  localparam logic [EXP_W-1:0] FP16_EXP_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } fp2int_state_t;

  typedef struct packed {
    logic inexact;
    logic ovf;
    logic neg;
    logic inv;
  } fp2int_flags_t;

endpackage

// File: rtl/fp_fp2int_seq_if.sv
// Valid/ready bundle between a producer of FP16 operands / consumer of
// integer results (master) and the converter (slave).
interface fp_fp2int_seq_if;
  import fp_fp2int_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FP16_W-1:0] fp_num;
  logic              out_valid;
  logic              out_ready;
  logic [INT_W-1:0]  int_num;
  logic              flag_inexact;
  logic              flag_ovf;
  logic              flag_neg;
  logic              flag_inv;

  modport master (
    output in_valid, fp_num, out_ready,
    input  in_ready, out_valid, int_num,
    input  flag_inexact, flag_ovf, flag_neg, flag_inv
  );

  modport slave (
    input  in_valid, fp_num, out_ready,
    output in_ready, out_valid, int_num,
    output flag_inexact, flag_ovf, flag_neg, flag_inv
  );

endinterface

// File: rtl/fp_fp16_classify.sv
// Combinational FP16 operand classification and shift-count extraction.
// is_small covers normal values below 1.0 (exponent 1..14); zero and
// subnormals are reported separately through is_zero / is_sub.
module fp_fp16_classify
  import fp_fp2int_seq_pkg::*;
(
  input  logic [FP16_W-1:0] fp_num,
  output logic              is_zero,
  output logic              is_sub,
  output logic              is_inf,
  output logic              is_nan,
  output logic              is_neg,
  output logic              is_small,
  output logic [EXP_W-1:0]  cnt
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant;

  assign exp_f    = fp_num[FP16_W-2 -: EXP_W];
  assign mant     = fp_num[MANT_W-1:0];

  assign is_zero  = (exp_f == '0) && (mant == '0);
  assign is_sub   = (exp_f == '0) && (mant != '0);
  assign is_inf   = (exp_f == FP16_EXP_MAX) && (mant == '0);
  assign is_nan   = (exp_f == FP16_EXP_MAX) && (mant != '0);
  assign is_neg   = fp_num[FP16_W-1];
  assign is_small = (exp_f != '0) && (exp_f < FP16_BIAS);
  // Left-shift distance for values >= 1.0; zero for everything else.
  assign cnt      = ((exp_f >= FP16_BIAS) && (exp_f != FP16_EXP_MAX)) ?
                    (exp_f - FP16_BIAS) : '0;

endmodule

// File: rtl/fp_fp2int_seq.sv
// Iterative FP16 -> unsigned 16-bit integer converter (truncate toward zero).
// A Q16.10 accumulator holding 1.mant is shifted left at most SHIFT_STEP
// places per cycle until the unbiased exponent is used up.
// Specials are resolved at load time and skip the accumulator.
module fp_fp2int_seq
  import fp_fp2int_seq_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  fp_fp2int_seq_if.slave  bus
);

  localparam logic [EXP_W-1:0] STEP = EXP_W'(SHIFT_STEP);

  fp2int_state_t    state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [EXP_W-1:0] cnt_q;
  logic             bypass_q;
  logic [INT_W-1:0] int_q;
  fp2int_flags_t    flags_q;
  logic             out_valid_q;

  logic             is_zero, is_sub, is_inf, is_nan, is_neg, is_small;
  logic [EXP_W-1:0] cls_cnt;
  logic [INT_W-1:0] pre_int;
  fp2int_flags_t    pre_flags;
  logic             pre_bypass;
  logic             accept, handshake;
  logic [EXP_W-1:0] step;

  fp_fp16_classify u_classify (
    .fp_num   (bus.fp_num),
    .is_zero  (is_zero),
    .is_sub   (is_sub),
    .is_inf   (is_inf),
    .is_nan   (is_nan),
    .is_neg   (is_neg),
    .is_small (is_small),
    .cnt      (cls_cnt)
  );

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign handshake = out_valid_q && bus.out_ready;
  assign step      = (cnt_q > STEP) ? STEP : cnt_q;

  // Preset result for special operands; NaN outranks sign, -0 raises nothing.
  always_comb begin
    pre_int    = '0;
    pre_flags  = '0;
    pre_bypass = 1'b1;
    if (is_nan) begin
      pre_flags.inv = 1'b1;
    end else if (is_neg && !is_zero) begin
      pre_flags.neg = 1'b1;
    end else if (is_inf) begin
      pre_int       = '1;
      pre_flags.ovf = 1'b1;
    end else if (is_sub || is_small) begin
      pre_flags.inexact = 1'b1;
    end else if (!is_zero) begin
      pre_bypass = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)          state_d = SHIFT;
      SHIFT:   if (cnt_q == '0)     state_d = DONE;
      DONE:    if (handshake)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Accumulator/count load and shift, result capture on leaving SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      bypass_q <= 1'b0;
      int_q    <= '0;
      flags_q  <= '0;
    end else if (state_q == IDLE && accept) begin
      acc_q    <= {{(ACC_W-MANT_W-1){1'b0}}, 1'b1, bus.fp_num[MANT_W-1:0]};
      cnt_q    <= pre_bypass ? '0 : cls_cnt;
      bypass_q <= pre_bypass;
      int_q    <= pre_int;
      flags_q  <= pre_flags;
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        acc_q <= acc_q << step;
        cnt_q <= cnt_q - step;
      end else if (!bypass_q) begin
        int_q           <= acc_q[ACC_W-1:MANT_W];
        flags_q.inexact <= |acc_q[MANT_W-1:0];
      end
    end
  end

  // Result becomes visible one cycle into DONE and drops after the handshake.
  always_ff @(posedge clk) begin
    if (reset) out_valid_q <= 1'b0;
    else       out_valid_q <= (state_q == DONE) && !handshake;
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.int_num      = int_q;
  assign bus.flag_inexact = flags_q.inexact;
  assign bus.flag_ovf     = flags_q.ovf;
  assign bus.flag_neg     = flags_q.neg;
  assign bus.flag_inv     = flags_q.inv;

endmodule

// File: tb/tb_fp_fp2int_seq.sv
// Bench for fp_fp2int_seq: directed FP16 vectors with literal expectations,
// plus a value-level reference model checked whenever out_valid is high.
module tb_fp_fp2int_seq;

  localparam int STEP = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] cur_fp;
  logic [19:0] mdl;

  fp_fp2int_seq_if bus ();

  fp_fp2int_seq #(.SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Flags packed as {inexact, ovf, neg, inv}.
  function automatic logic [3:0] flags_now();
    return {bus.flag_inexact, bus.flag_ovf, bus.flag_neg, bus.flag_inv};
  endfunction

  // Reference: scale the exact FP16 magnitude by 2^25 so it is an integer,
  // then the integer part is the top bits and any lower bits mean inexact.
  function automatic logic [19:0] model(input logic [15:0] f);
    int     e = int'(f[14:10]);
    int     m = int'(f[9:0]);
    longint full;
    if (e == 31) begin
      if (m != 0) return {4'b0001, 16'h0000};
      if (f[15])  return {4'b0010, 16'h0000};
      return {4'b0100, 16'hFFFF};
    end
    if (e == 0) full = longint'(m) * 2;
    else        full = longint'(1024 + m) << e;
    if (full == 0) return 20'h0;
    if (f[15])     return {4'b0010, 16'h0000};
    return {(full[24:0] != 0), 3'b000, 16'(full >>> 25)};
  endfunction

  // Every cycle with a presented result, outputs must match the model.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1) begin
      mdl = model(cur_fp);
      check("model_int", 32'(bus.int_num), 32'(mdl[15:0]));
      check("model_flags", 32'(flags_now()), 32'(mdl[19:16]));
      check("model_in_ready", 32'(bus.in_ready), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] fp);
    int t = 0;
    bus.fp_num   = fp;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("accept_wait", 32'(t < 20), 32'd1);
    tick();
    cur_fp       = fp;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int exp_lat);
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic finish_out(input string name, input logic [15:0] ei, input logic [3:0] ef, input int hold);
    check({name, "_int"}, 32'(bus.int_num), 32'(ei));
    check({name, "_flags"}, 32'(flags_now()), 32'(ef));
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      tick();
      check({name, "_hold_int"}, 32'(bus.int_num), 32'(ei));
      check({name, "_hold_flags"}, 32'(flags_now()), 32'(ef));
      check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({name, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run(input string name, input logic [15:0] fp, input logic [15:0] ei,
                     input logic [3:0] ef, input int lat, input int hold);
    send(fp);
    wait_out(name, lat);
    finish_out(name, ei, ef, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_valid;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.fp_num    = 16'h0000;
    cur_fp        = 16'h0000;
    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_int", 32'(bus.int_num), 32'd0);
    check("rst_flags", 32'(flags_now()), 32'd0);
    reset = 1'b0;
    tick();

    // Pin the reference model against hand-derived values.
    check("pin_model_3C00", 32'(model(16'h3C00)), 32'h00001);
    check("pin_model_5640", 32'(model(16'h5640)), 32'h00064);
    check("pin_model_3E00", 32'(model(16'h3E00)), 32'h80001);
    check("pin_model_0001", 32'(model(16'h0001)), 32'h80000);
    check("pin_model_7BFF", 32'(model(16'h7BFF)), 32'h0FFE0);

    //   name        fp        int       flags   lat hold
    run("one",       16'h3C00, 16'h0001, 4'b0000, 2, 0);
    run("hundred",   16'h5640, 16'h0064, 4'b0000, 4, 0);
    run("max_fin",   16'h7BFF, 16'hFFE0, 4'b0000, 6, 0);
    run("ten",       16'h4900, 16'h000A, 4'b0000, 3, 0);
    run("sixteen",   16'h4C00, 16'h0010, 4'b0000, 3, 0);
    run("one_half",  16'h3E00, 16'h0001, 4'b1000, 2, 0);
    run("half",      16'h3800, 16'h0000, 4'b1000, 2, 0);
    run("tiny_sub",  16'h0001, 16'h0000, 4'b1000, 2, 0);
    run("pos_zero",  16'h0000, 16'h0000, 4'b0000, 2, 0);
    run("pinf",      16'h7C00, 16'hFFFF, 4'b0100, 2, 0);
    run("qnan",      16'h7E00, 16'h0000, 4'b0001, 2, 0);
    run("neg_nan",   16'hFE00, 16'h0000, 4'b0001, 2, 0);
    run("neg_two",   16'hC000, 16'h0000, 4'b0010, 2, 0);
    run("ninf",      16'hFC00, 16'h0000, 4'b0010, 2, 0);
    run("neg_zero",  16'h8000, 16'h0000, 4'b0000, 2, 0);

    // Backpressure, then a new operand waiting with in_valid during the handshake.
    send(16'h5640);
    wait_out("bp", 4);
    check("bp_int", 32'(bus.int_num), 32'h0064);
    repeat (3) begin
      tick();
      check("bp_hold_int", 32'(bus.int_num), 32'h0064);
      check("bp_hold_flags", 32'(flags_now()), 32'd0);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.fp_num    = 16'h3C00;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    check("bp_idle", 32'(bus.in_ready), 32'd1);
    tick();
    cur_fp       = 16'h3C00;
    bus.in_valid = 1'b0;
    check("bp_next_accepted", 32'(bus.in_ready), 32'd0);
    wait_out("bp_next", 2);
    finish_out("bp_next", 16'h0001, 4'b0000, 0);

    // Reset while shifting aborts the conversion.
    send(16'h7BFF);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_int", 32'(bus.int_num), 32'd0);
    check("abort_flags", 32'(flags_now()), 32'd0);
    reset = 1'b0;
    seen_valid = 0;
    repeat (8) begin
      tick();
      if (bus.out_valid !== 1'b0) seen_valid++;
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);
    run("after_reset", 16'h3C00, 16'h0001, 4'b0000, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
